uart_transmitter: RTL and testbench

- UART serial transmitter; the transmit-side counterpart of the existing UART receiver in the RISC-V UART subsystem.
- Accepts a parallel byte on a one-cycle start strobe and serialises it LSB-first as: start bit, DBIT data bits, optional parity bit, stop bit(s).
- Bit timing comes from the shared 16x-oversampling s_tick from the baud-rate generator that also feeds the receiver.
- Feeds the board TX pin directly; tx_done_tick is the handshake back to the TX FIFO / bus interface.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_transmitter.sv | 134 +++++++++++++
 tb/tb_uart_transmitter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity modes and oversampling ratio.
// Used by both the transmitter and the receiver of the UART subsystem.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Parity over the low dbit bits of data; odd mode inverts the plain XOR.
  function automatic logic parity_bit(input logic [7:0] data, input int dbit, input int mode);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < dbit) p = p ^ data[i];
    end
    if (mode == PAR_ODD)       return ~p;
    else if (mode == PAR_EVEN) return p;
    else                       return 1'b1;
  endfunction

endpackage

// File: rtl/uart_transmitter.sv
// UART transmitter: start, DBIT data bits LSB-first, optional parity, stop; paced by 16x s_tick.
// tx is registered from the current state, so the line moves one clk after each state change.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic       s_tick,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);

  localparam bit       HAS_PARITY = (PARITY != PAR_NONE);
  localparam [4:0]     S_BIT_LAST  = 5'(OVERSAMPLE - 1);
  localparam [4:0]     S_STOP_LAST = 5'(SB_TICK - 1);
  localparam [2:0]     N_LAST      = 3'(DBIT - 1);

  uart_state_e state_q, state_d;
  logic [4:0]  s_q, s_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  b_q, b_d;
  logic        p_q, p_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Acceptance in idle ignores s_tick, so a coincident tick is never counted.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          state_d = ST_START;
          s_d     = '0;
          b_d     = din;
          p_d     = parity_bit(din, DBIT, PARITY);
        end
      end
      ST_START: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            n_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d = '0;
            b_d = {1'b0, b_q[7:1]};
            if (n_q == N_LAST) state_d = HAS_PARITY ? ST_PARITY : ST_STOP;
            else               n_d     = n_q + 3'd1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP_LAST) begin
            s_d     = '0;
            state_d = ST_IDLE;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = b_q[0];
      ST_PARITY: tx_d = p_q;
      default:   tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    done_d = (state_q == ST_STOP) && s_tick && (s_q == S_STOP_LAST);
  end

  assign tx           = tx_q;
  assign tx_busy      = busy_q;
  assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: four parameterisations share one stimulus; a line monitor
// decodes each frame by sampling tx at mid-bit (tick 8 of every 16) and counts frame ticks.
module tb_uart_transmitter;

  localparam int TP = 3;  // clks per s_tick

  logic       clk = 1'b0;
  logic       reset, tx_start, s_tick, tick_en;
  logic [7:0] din;
  logic [3:0] tx_w, busy_w, done_w;
  int         div;

  int errors = 0;
  int checks = 0;

  bit          act[4];
  int          ticks[4], nbits[4], frames[4], last_ticks[4];
  int          gap[4], last_gap[4], busy_viol[4], done_wide[4];
  logic [15:0] bits[4], last_bits[4], prev_bits[4];
  logic        done_prev[4];

  typedef struct {
    int          k;
    logic [7:0]  d;
    logic [15:0] bits;
    int          ticks;
    bit          align;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  // 0: 8N1, 1: 8O1, 2: 8E1, 3: 8N2 (SB_TICK=32)
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(0)) u_8n1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx(tx_w[0]), .tx_busy(busy_w[0]), .tx_done_tick(done_w[0]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(1)) u_8o1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx(tx_w[1]), .tx_busy(busy_w[1]), .tx_done_tick(done_w[1]));
  uart_transmitter #(.DBIT(8), .SB_TICK(16), .PARITY(2)) u_8e1 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx(tx_w[2]), .tx_busy(busy_w[2]), .tx_done_tick(done_w[2]));
  uart_transmitter #(.DBIT(8), .SB_TICK(32), .PARITY(0)) u_8n2 (
    .clk(clk), .reset(reset), .tx_start(tx_start), .s_tick(s_tick), .din(din),
    .tx(tx_w[3]), .tx_busy(busy_w[3]), .tx_done_tick(done_w[3]));

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act_v, exp_v);
    end
  endtask

  task automatic monitor();
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        act[k] = 1'b0;
        gap[k] = 0;
      end else begin
        if (done_w[k] && done_prev[k]) done_wide[k]++;
        if (!act[k]) begin
          if (tx_w[k] == 1'b0) begin
            act[k]      = 1'b1;
            ticks[k]    = 0;
            bits[k]     = '0;
            nbits[k]    = 0;
            last_gap[k] = gap[k];
          end else if (s_tick) begin
            gap[k]++;
          end
          if (!act[k] && done_w[k]) frames[k]++;
        end
        if (act[k]) begin
          if (s_tick) begin
            ticks[k]++;
            if (ticks[k] % 16 == 8) begin
              if (nbits[k] < 16) bits[k] = bits[k] | (16'(tx_w[k]) << nbits[k]);
              nbits[k]++;
            end
          end
          if (done_w[k]) begin
            frames[k]++;
            prev_bits[k]  = last_bits[k];
            last_bits[k]  = bits[k];
            last_ticks[k] = ticks[k];
            act[k]        = 1'b0;
            gap[k]        = 0;
          end else if (!busy_w[k]) begin
            busy_viol[k]++;
          end
        end
      end
      done_prev[k] = done_w[k];
    end
  endtask

  task automatic step();
    @(negedge clk);
    s_tick = tick_en && (div == TP - 1);
    div    = (div == TP - 1) ? 0 : div + 1;
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic send(input logic [7:0] d, input bit align);
    if (align) while (div != TP - 1) step();
    din      = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_w != 4'h0 && n < 3000) begin
      step();
      n++;
    end
    check(name, busy_w, 4'h0);
  endtask

  task automatic wait_ticks(input int k, input int t, input string name);
    int n;
    n = 0;
    while (!(act[k] && ticks[k] >= t) && n < 3000) begin
      step();
      n++;
    end
    check(name, ticks[k], t);
  endtask

  function automatic int total_frames();
    return frames[0] + frames[1] + frames[2] + frames[3];
  endfunction

  initial begin
    int          f0, n, chg, viol, wide;
    logic        hold;

    vecs[0] = '{0, 8'h55, 16'h02AA, 160, 1'b0};
    vecs[1] = '{2, 8'h07, 16'h060E, 176, 1'b0};
    vecs[2] = '{1, 8'h07, 16'h040E, 176, 1'b1};
    vecs[3] = '{0, 8'h00, 16'h0200, 160, 1'b1};
    vecs[4] = '{0, 8'hFF, 16'h03FE, 160, 1'b0};
    vecs[5] = '{2, 8'hFF, 16'h05FE, 176, 1'b0};
    vecs[6] = '{1, 8'hFF, 16'h07FE, 176, 1'b1};
    vecs[7] = '{2, 8'h80, 16'h0700, 176, 1'b0};
    vecs[8] = '{3, 8'h81, 16'h0702, 176, 1'b1};
    vecs[9] = '{0, 8'hA3, 16'h0346, 160, 1'b1};

    for (int k = 0; k < 4; k++) begin
      act[k] = 1'b0; ticks[k] = 0; nbits[k] = 0; frames[k] = 0; last_ticks[k] = 0;
      gap[k] = 0; last_gap[k] = 0; busy_viol[k] = 0; done_wide[k] = 0;
      bits[k] = '0; last_bits[k] = '0; prev_bits[k] = '0; done_prev[k] = 1'b0;
    end
    reset = 1'b1; tx_start = 1'b0; s_tick = 1'b0; din = 8'h00; tick_en = 1'b1; div = 0;

    repeat (4) step();
    check("reset tx", tx_w, 4'hF);
    check("reset busy", busy_w, 4'h0);
    check("reset done", done_w, 4'h0);
    reset = 1'b0;
    repeat (10) step();
    check("idle tx", tx_w, 4'hF);
    check("idle busy", busy_w, 4'h0);

    for (int i = 0; i < 10; i++) begin
      f0 = frames[vecs[i].k];
      send(vecs[i].d, vecs[i].align);
      wait_idle($sformatf("row%0d idle", i));
      check($sformatf("row%0d bits", i), last_bits[vecs[i].k], vecs[i].bits);
      check($sformatf("row%0d ticks", i), last_ticks[vecs[i].k], vecs[i].ticks);
      check($sformatf("row%0d frames", i), frames[vecs[i].k] - f0, 1);
    end

    // tx_start mid-frame with different din must be ignored
    f0 = frames[0];
    send(8'hA3, 1'b0);
    wait_ticks(0, 50, "t3 reach");
    din = 8'hFF; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    wait_idle("t3 idle");
    check("t3 bits", last_bits[0], 16'h0346);
    check("t3 ticks", last_ticks[0], 160);
    repeat (60) step();
    check("t3 no queued busy", busy_w, 4'h0);
    check("t3 frames", frames[0] - f0, 1);

    // back-to-back: second start in the done cycle
    f0 = frames[0];
    send(8'h12, 1'b0);
    n = 0;
    while (!done_w[0] && n < 3000) begin
      step();
      n++;
    end
    check("t4 first done", done_w[0], 1'b1);
    din = 8'h34; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    wait_idle("t4 idle");
    check("t4 first bits", prev_bits[0], 16'h0224);
    check("t4 second bits", last_bits[0], 16'h0268);
    check("t4 gap ticks", last_gap[0], 0);
    check("t4 second ticks", last_ticks[0], 160);
    check("t4 frames", frames[0] - f0, 2);

    // reset at tick 70 of a frame of zeros
    send(8'h00, 1'b0);
    wait_ticks(0, 70, "t5 reach");
    check("t5 tx low before reset", tx_w[0], 1'b0);
    reset = 1'b1;
    step();
    check("t5 tx after reset", tx_w, 4'hF);
    check("t5 busy after reset", busy_w, 4'h0);
    check("t5 done after reset", done_w, 4'h0);
    reset = 1'b0;
    f0 = total_frames();
    repeat (600) step();
    check("t5 no done", total_frames() - f0, 0);
    check("t5 idle tx", tx_w, 4'hF);
    send(8'h3C, 1'b1);
    wait_idle("t5 resend idle");
    check("t5 resend bits", last_bits[0], 16'h0278);
    check("t5 resend ticks", last_ticks[0], 160);

    // SB_TICK=32 with s_tick gated off mid-data
    f0 = frames[3];
    send(8'h5A, 1'b0);
    wait_ticks(3, 40, "t6 reach");
    tick_en = 1'b0;
    step();
    step();
    hold = tx_w[3];
    chg  = 0;
    repeat (100) begin
      step();
      if (tx_w[3] !== hold) chg++;
    end
    check("t6 held bit", hold, 1'b1);
    check("t6 tx changes in gap", chg, 0);
    check("t6 busy in gap", busy_w[3], 1'b1);
    tick_en = 1'b1;
    wait_idle("t6 idle");
    check("t6 bits", last_bits[3], 16'h06B4);
    check("t6 ticks", last_ticks[3], 176);
    check("t6 frames", frames[3] - f0, 1);

    viol = 0;
    wide = 0;
    for (int k = 0; k < 4; k++) begin
      viol += busy_viol[k];
      wide += done_wide[k];
    end
    check("busy low inside frame", viol, 0);
    check("done wider than one clk", wide, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
